multiplexer_dataflow: RTL and testbench

- 4:1 selector: output Y is lane X[C] of a 4-lane input bus; the default lane width is 1 bit.
- Y is pure dataflow (combinational) and is the primary output.
- A clocked, registered copy of the selection is provided for downstream synchronous logic.
- Sits at the datapath/control boundary wherever one of four sources must be steered to a single sink.

---
 rtl/multiplexer_dataflow.sv | 65 ++++++
 tb/tb_multiplexer_dataflow.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/multiplexer_dataflow.sv
// 4:1 lane selector: combinational output Y plus an enable-loaded registered copy.
// Optional feature macro MUX_PARITY_EN adds Y_par (combinational) and Y_par_q (registered).
module multiplexer_dataflow #(
  parameter int DATA_W = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [4*DATA_W-1:0] X,
  input  logic [1:0]          C,
  input  logic                en,
  output logic [DATA_W-1:0]   Y,
  output logic [DATA_W-1:0]   Y_q,
  output logic [1:0]          C_q,
  output logic                valid_q
`ifdef MUX_PARITY_EN
  ,
  output logic                Y_par,
  output logic                Y_par_q
`endif
);

  logic [DATA_W-1:0] w_sel;
  logic [DATA_W-1:0] r_y_q;
  logic [1:0]        r_c_q;
  logic              r_valid_q;

  // Plain indexed part-select keeps standard X/Z propagation from C and X.
  assign w_sel = X[C*DATA_W +: DATA_W];
  assign Y     = w_sel;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_y_q     <= '0;
      r_c_q     <= '0;
      r_valid_q <= 1'b0;
    end else if (en) begin
      r_y_q     <= w_sel;
      r_c_q     <= C;
      r_valid_q <= 1'b1;
    end
  end

  assign Y_q     = r_y_q;
  assign C_q     = r_c_q;
  assign valid_q = r_valid_q;

`ifdef MUX_PARITY_EN
  logic w_par;
  logic r_par_q;

  assign w_par = ^w_sel;
  assign Y_par = w_par;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_par_q <= 1'b0;
    end else if (en) begin
      r_par_q <= w_par;
    end
  end

  assign Y_par_q = r_par_q;
`endif

endmodule

// File: tb/tb_multiplexer_dataflow.sv
// Scoreboard bench for multiplexer_dataflow: 1-bit and 8-bit lane instances share controls.
module tb_multiplexer_dataflow;

  logic        clk;
  logic        rst_n;
  logic [1:0]  C;
  logic        en;
  logic [3:0]  x1;
  logic [31:0] x8;
  logic        y1, y1_q;
  logic [1:0]  c1_q;
  logic        v1_q;
  logic [7:0]  y8, y8_q;
  logic [1:0]  c8_q;
  logic        v8_q;
`ifdef MUX_PARITY_EN
  logic        p1, p1_q, p8, p8_q;
`endif

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic       y1;
    logic [7:0] y8;
    logic [1:0] c;
    logic       v;
    logic       p8;
  } exp_t;

  exp_t sb[$];

  // Reference register state, expressed directly from the load/hold/reset rules
  logic       m_y1;
  logic [7:0] m_y8;
  logic [1:0] m_c;
  logic       m_v;
  logic       m_p8;

  multiplexer_dataflow #(.DATA_W(1)) u_w1 (
    .clk(clk), .rst_n(rst_n), .X(x1), .C(C), .en(en),
    .Y(y1), .Y_q(y1_q), .C_q(c1_q), .valid_q(v1_q)
`ifdef MUX_PARITY_EN
    , .Y_par(p1), .Y_par_q(p1_q)
`endif
  );

  multiplexer_dataflow #(.DATA_W(8)) u_w8 (
    .clk(clk), .rst_n(rst_n), .X(x8), .C(C), .en(en),
    .Y(y8), .Y_q(y8_q), .C_q(c8_q), .valid_q(v8_q)
`ifdef MUX_PARITY_EN
    , .Y_par(p8), .Y_par_q(p8_q)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic ref_sel1(input logic [3:0] x, input logic [1:0] c);
    return logic'((x >> c) & 4'd1);
  endfunction

  function automatic logic [7:0] ref_sel8(input logic [31:0] x, input logic [1:0] c);
    logic [31:0] t;
    t = x / (32'd1 << (8 * c));
    return t[7:0];
  endfunction

  function automatic logic ref_par(input logic [7:0] v);
    int unsigned n;
    n = 0;
    for (int unsigned i = 0; i < 8; i++) n += v[i];
    return logic'(n % 2);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
    end
  endtask

  // One clocked cycle: drive after the sampling negedge, check Y, predict registers.
  task automatic step(input logic [3:0] xa, input logic [31:0] xb, input logic [1:0] c,
                      input logic e, input logic r);
    exp_t ex;
    @(negedge clk);
    #1;
    x1 = xa; x8 = xb; C = c; en = e; rst_n = r;
    #1;
    chk("Y_w1", 32'(y1), 32'(ref_sel1(xa, c)));
    chk("Y_w8", 32'(y8), 32'(ref_sel8(xb, c)));
`ifdef MUX_PARITY_EN
    chk("Y_par_w8", 32'(p8), 32'(ref_par(ref_sel8(xb, c))));
    chk("Y_par_w1", 32'(p1), 32'(ref_sel1(xa, c)));
`endif
    if (!r) begin
      m_y1 = 1'b0; m_y8 = 8'h00; m_c = 2'd0; m_v = 1'b0; m_p8 = 1'b0;
    end else if (e) begin
      m_y1 = ref_sel1(xa, c); m_y8 = ref_sel8(xb, c); m_c = c; m_v = 1'b1;
      m_p8 = ref_par(m_y8);
    end
    ex.y1 = m_y1; ex.y8 = m_y8; ex.c = m_c; ex.v = m_v; ex.p8 = m_p8;
    sb.push_back(ex);
  endtask

  // Monitor: each negedge, compare the registered outputs with the oldest prediction
  always @(negedge clk) begin
    if (sb.size() > 0) begin
      exp_t ex;
      ex = sb.pop_front();
      chk("Y_q_w1", 32'(y1_q), 32'(ex.y1));
      chk("Y_q_w8", 32'(y8_q), 32'(ex.y8));
      chk("C_q_w1", 32'(c1_q), 32'(ex.c));
      chk("C_q_w8", 32'(c8_q), 32'(ex.c));
      chk("valid_q", 32'({v1_q, v8_q}), 32'({ex.v, ex.v}));
`ifdef MUX_PARITY_EN
      chk("Y_par_q_w8", 32'(p8_q), 32'(ex.p8));
      chk("Y_par_q_w1", 32'(p1_q), 32'(ex.y1));
`endif
    end
  end

  initial begin
    int unsigned waited;
    rst_n = 1'b0; en = 1'b0; C = 2'd0; x1 = '0; x8 = '0;
    m_y1 = 1'b0; m_y8 = 8'h00; m_c = 2'd0; m_v = 1'b0; m_p8 = 1'b0;

    // Exhaustive 1-bit sweep under reset; registers must also stay cleared
    for (int xi = 0; xi < 16; xi++) begin
      for (int ci = 0; ci < 4; ci++) begin
        x1 = 4'(xi); C = 2'(ci); x8 = $urandom;
        #100;
        chk("sweep_Y", 32'(y1), 32'(ref_sel1(4'(xi), 2'(ci))));
        chk("sweep_Y8", 32'(y8), 32'(ref_sel8(x8, 2'(ci))));
      end
    end
    chk("rst_regs", 32'({y1_q, y8_q, c1_q, c8_q, v1_q, v8_q}), 32'd0);

    // Directed load then hold
    step(4'b0100, 32'hDDCCBBAA, 2'd2, 1'b1, 1'b1);
    step(4'b0100, 32'hDDCCBBAA, 2'd0, 1'b0, 1'b1);
    // Wide-lane selection of every lane, loaded each cycle
    for (int ci = 0; ci < 4; ci++) step(4'b1010, 32'hDDCCBBAA, 2'(ci), 1'b1, 1'b1);
    // Parity corner values
    step(4'b0001, 32'h000000AA, 2'd0, 1'b1, 1'b1);
    step(4'b0001, 32'h00070000, 2'd2, 1'b1, 1'b1);

    // Asynchronous reset mid-cycle: outputs clear with no clock edge
    @(negedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("async_rst", 32'({y1_q, y8_q, c1_q, c8_q, v1_q, v8_q}), 32'd0);
    m_y1 = 1'b0; m_y8 = 8'h00; m_c = 2'd0; m_v = 1'b0; m_p8 = 1'b0;
    step(4'b1111, 32'hFFFFFFFF, 2'd3, 1'b1, 1'b0);
    // Release with en low: first load waits for en
    step(4'b1111, 32'hFFFFFFFF, 2'd3, 1'b0, 1'b1);
    step(4'b1000, 32'h12345678, 2'd3, 1'b1, 1'b1);

    // Randomized traffic with occasional reset pulses
    for (int n = 0; n < 300; n++) begin
      step(4'($urandom), $urandom, 2'($urandom_range(0, 3)),
           ($urandom_range(0, 2) != 0), ($urandom_range(0, 30) != 0));
    end

    waited = 0;
    while (sb.size() > 0 && waited < 10) begin
      @(posedge clk);
      waited++;
    end
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d predictions left, expected 0", sb.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
